// File: rtl/ps2_device_tx.sv
// ps2_device_tx: PS/2 device-side transmitter fed from a byte FIFO.
//
// Bytes arrive as a level-style valid from an upstream receiver; each rising
// edge of in_valid pushes in_data into a FIFO. The FSM waits until both PS/2
// lines have been idle high for IDLE_CYC cycles, then clocks out one 11-bit
// frame (start 0, 8 data bits LSB first, odd parity, stop 1) by generating
// the PS/2 clock itself. Lines are open-drain: *_oe = 1 pulls the line low.
// If the host holds the clock low at the end of a clock-high phase the frame
// is abandoned and retried from the start bit; the byte is only popped once
// the stop bit has been clocked out.
//
// Handshake: in_valid is not a valid/ready pair; there is no back-pressure.
// A push is the cycle where in_valid is high and was low the cycle before.
// A push onto a full FIFO is dropped and sets the sticky overflow flag,
// unless a pop happens in the same cycle, in which case the slot is reused.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   in_valid, in_data   byte-ready level and byte from upstream
//   ps2_clk_i/data_i    sensed PS/2 clock and data lines
//   ps2_clk_oe/data_oe  1 pulls the corresponding line low
//   busy                FSM not idle or FIFO non-empty
//   overflow            sticky: a byte was dropped on a full FIFO
//   fifo_count          current FIFO occupancy
//   dbg_state_o         FSM state for observation
//
// FIFO_DEPTH must be a power of two and at least 2 (pointers wrap naturally).
module ps2_device_tx #(
   parameter int CLK        = 50000000,
   parameter int PS2_CLK_HZ = 12500,
   parameter int IDLE_CYC   = 2500,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic [7:0]                  in_data,
   input  logic                        ps2_clk_i,
   input  logic                        ps2_data_i,
   output logic                        ps2_clk_oe,
   output logic                        ps2_data_oe,
   output logic                        busy,
   output logic                        overflow,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic [1:0]                  dbg_state_o
);

   localparam int HALF    = CLK / (2 * PS2_CLK_HZ);
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int NW      = AW + 1;
   localparam int CNT_MAX = (HALF > IDLE_CYC) ? HALF : IDLE_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
   localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYC - 1);
   localparam logic [NW-1:0] DEPTH_C   = NW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GAP      = 2'd1,
      BIT_HIGH = 2'd2,
      BIT_LOW  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [3:0]      idx_q, idx_d;
   logic [10:0]     frame_q, frame_d;
   logic            in_valid_q;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [NW-1:0]   count_q;
   logic            overflow_q;

   logic            push, push_ok, pop, full, empty;
   logic [7:0]      head;

   assign push    = in_valid & ~in_valid_q;
   assign full    = (count_q == DEPTH_C);
   assign empty   = (count_q == '0);
   // A simultaneous pop frees the slot the push needs.
   assign push_ok = push & (~full | pop);
   assign head    = mem_q[rd_ptr_q];

   // ---------------- FSM next state ----------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      frame_d = frame_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               state_d = GAP;
               cnt_d   = '0;
            end
         end
         GAP: begin
            // Count consecutive cycles with both lines released and high.
            if (ps2_clk_i && ps2_data_i) begin
               if (cnt_q == IDLE_LAST) begin
                  state_d = BIT_HIGH;
                  cnt_d   = '0;
                  idx_d   = '0;
                  frame_d = {1'b1, ~^head, head, 1'b0};
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               cnt_d = '0;
            end
         end
         BIT_HIGH: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               // Host holding the clock low here means inhibit: retry later.
               if (!ps2_clk_i) begin
                  state_d = GAP;
               end else begin
                  state_d = BIT_LOW;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         BIT_LOW: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (idx_q == 4'd10) begin
                  pop     = 1'b1;
                  state_d = IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = BIT_HIGH;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- state and FIFO registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         frame_q    <= '0;
         in_valid_q <= 1'b1;   // a level already high at reset release is not a push
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         frame_q    <= frame_d;
         in_valid_q <= in_valid;
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (push_ok && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !push_ok) begin
            count_q <= count_q - 1'b1;
         end
         if (push && !push_ok) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   // ---------------- outputs ----------------
   assign ps2_clk_oe  = (state_q == BIT_LOW);
   assign ps2_data_oe = ((state_q == BIT_HIGH) || (state_q == BIT_LOW)) & ~frame_q[idx_q];
   assign busy        = (state_q != IDLE) | ~empty;
   assign overflow    = overflow_q;
   assign fifo_count  = count_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx with CLK=8, PS2_CLK_HZ=1 (4-cycle half periods),
// IDLE_CYC=3, FIFO_DEPTH=8. Both PS/2 lines are pulled up unless the device
// or the emulated host pulls them low. A protocol monitor decodes frames from
// the bus and checks them against a byte queue fed by in_valid rising edges.
module tb_ps2_device_tx;

   localparam int HALF     = 4;
   localparam int IDLE_CYC = 3;
   localparam int DEPTH    = 8;

   // ---------------- clock / reset / DUT ----------------
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       host_clk_low = 1'b0;
   logic       host_data_low = 1'b0;
   logic       ps2_clk_line, ps2_data_line;
   logic       ps2_clk_oe, ps2_data_oe, busy, overflow;
   logic [3:0] fifo_count;
   logic [1:0] dbg_state;

   always #5 clk = ~clk;

   assign ps2_clk_line  = ~(ps2_clk_oe | host_clk_low);
   assign ps2_data_line = ~(ps2_data_oe | host_data_low);

   ps2_device_tx #(
      .CLK        (8),
      .PS2_CLK_HZ (1),
      .IDLE_CYC   (IDLE_CYC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .ps2_clk_i   (ps2_clk_line),
      .ps2_data_i  (ps2_data_line),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .busy        (busy),
      .overflow    (overflow),
      .fifo_count  (fifo_count),
      .dbg_state_o (dbg_state)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model + bus monitor ----------------
   logic [7:0]  exp_q[$];
   logic        exp_ovf = 1'b0;
   logic        prev_inv = 1'b1;
   logic        smp_rst = 1'b1, smp_inv = 1'b1, mon_en = 1'b0;
   logic [7:0]  smp_data = 8'h00;
   int          nbits = 0, lo_run = 0, hi_run = 100;
   int          n_frames = 0, n_aborts = 0;
   logic        cur_bit = 1'b1;
   logic [10:0] frame_v = '0, last_frame = '0;
   logic [7:0]  exp_b;

   always @(posedge clk) begin
      smp_rst  <= rst;
      smp_inv  <= in_valid;
      smp_data <= in_data;
      mon_en   <= 1'b1;
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (smp_rst) begin
            exp_q.delete();
            exp_ovf  = 1'b0;
            prev_inv = 1'b1;
            nbits    = 0;
            lo_run   = 0;
            hi_run   = 100;
         end else begin
            // Frame decoding: a bit is the data line level during a clock-low pulse.
            if (ps2_clk_oe) begin
               if (lo_run == 0) begin
                  // Bits within a frame are exactly HALF cycles apart; anything else starts a new frame.
                  if (hi_run != HALF) begin
                     if (nbits != 0) n_aborts++;
                     nbits = 0;
                  end
                  cur_bit = ps2_data_line;
               end else begin
                  check("data_hold", ps2_data_line, cur_bit);
               end
               lo_run++;
            end else if (lo_run != 0) begin
               check("low_width", lo_run, HALF);
               frame_v[nbits] = cur_bit;
               nbits++;
               if (nbits == 11) begin
                  n_frames++;
                  last_frame = frame_v;
                  check("queue_nonempty", (exp_q.size() != 0), 1);
                  if (exp_q.size() != 0) begin
                     exp_b = exp_q.pop_front();
                     check("start_bit", frame_v[0], 0);
                     check("data_byte", frame_v[8:1], exp_b);
                     check("parity_bit", frame_v[9], ~^exp_b);
                     check("stop_bit", frame_v[10], 1);
                  end
                  nbits = 0;
               end
               lo_run = 0;
               hi_run = 1;
            end else begin
               hi_run++;
            end
            // Byte arrivals, after any pop on the same edge.
            if (smp_inv && !prev_inv) begin
               if (exp_q.size() < DEPTH) exp_q.push_back(smp_data);
               else exp_ovf = 1'b1;
            end
            prev_inv = smp_inv;
         end
         check("fifo_count", fifo_count, exp_q.size());
         check("busy", busy, (exp_q.size() != 0));
         check("overflow", overflow, exp_ovf);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      in_valid = 1'b0;
      in_data  = b;
      tick();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_frames(input int target, input int budget);
      int k = 0;
      while (n_frames < target && k < budget) begin
         tick();
         k++;
      end
      check("wait_frames", (n_frames >= target), 1);
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0) && k < budget) begin
         tick();
         k++;
      end
      check("drain", exp_q.size(), 0);
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin : main
      int f0, a0, k;
      logic [7:0] b;

      // Reset, with in_valid already high across reset release.
      repeat (3) tick();
      check("rst_clk_oe", ps2_clk_oe, 0);
      check("rst_data_oe", ps2_data_oe, 0);
      check("rst_busy", busy, 0);
      check("rst_overflow", overflow, 0);
      check("rst_count", fifo_count, 0);
      check("rst_state", dbg_state, 0);
      rst = 1'b0;
      repeat (5) tick();
      check("no_push_at_release", fifo_count, 0);
      in_valid = 1'b0;
      tick();

      // 0xA5: exact bit sequence on the bus.
      f0 = n_frames;
      push_byte(8'hA5);
      wait_frames(f0 + 1, 300);
      check("a5_frame", last_frame, 11'h74A);
      repeat (2) tick();
      check("a5_count", fifo_count, 0);
      check("a5_busy", busy, 0);

      // Long valid level: one push, one frame.
      f0 = n_frames;
      in_data  = 8'h3C;
      in_valid = 1'b1;
      repeat (100) tick();
      in_valid = 1'b0;
      wait_frames(f0 + 1, 300);
      check("3c_parity", last_frame[9], 1);
      repeat (120) tick();
      check("3c_one_frame", n_frames, f0 + 1);

      // Overflow while host inhibits the clock.
      f0 = n_frames;
      host_clk_low = 1'b1;
      for (int i = 0; i < 9; i++) push_byte(8'($urandom_range(0, 255)));
      repeat (3) tick();
      check("ovf_count", fifo_count, 8);
      check("ovf_flag", overflow, 1);
      check("ovf_no_tx", n_frames, f0);
      host_clk_low = 1'b0;
      wait_frames(f0 + 8, 1000);

      // Data held low blocks the gap.
      f0 = n_frames;
      host_data_low = 1'b1;
      push_byte(8'($urandom_range(0, 255)));
      repeat (40) tick();
      check("data_low_no_clk", ps2_clk_oe, 0);
      check("data_low_no_frame", n_frames, f0);
      host_data_low = 1'b0;
      wait_frames(f0 + 1, 300);

      // Host inhibit during the clock-high phase of bit 4.
      f0 = n_frames;
      a0 = n_aborts;
      push_byte(8'($urandom_range(0, 255)));
      k = 0;
      while (!(nbits == 4 && !ps2_clk_oe) && k < 300) begin tick(); k++; end
      check("reach_bit4", (k < 300), 1);
      host_clk_low = 1'b1;
      repeat (3) tick();
      check("abort_clk_oe", ps2_clk_oe, 0);
      check("abort_data_oe", ps2_data_oe, 0);
      check("abort_count", fifo_count, 1);
      repeat (5) tick();
      check("inhibit_clk_oe", ps2_clk_oe, 0);
      host_clk_low = 1'b0;
      wait_frames(f0 + 1, 300);
      check("abort_seen", n_aborts, a0 + 1);

      // Reset during the clock-low phase of bit 6 with 3 bytes queued.
      host_clk_low = 1'b1;
      for (int i = 0; i < 3; i++) push_byte(8'($urandom_range(0, 255)));
      host_clk_low = 1'b0;
      k = 0;
      while (!(nbits == 6 && ps2_clk_oe) && k < 300) begin tick(); k++; end
      check("reach_bit6", (k < 300), 1);
      rst = 1'b1;
      tick();
      check("mid_rst_clk_oe", ps2_clk_oe, 0);
      check("mid_rst_data_oe", ps2_data_oe, 0);
      check("mid_rst_count", fifo_count, 0);
      check("mid_rst_busy", busy, 0);
      rst = 1'b0;
      f0 = n_frames;
      repeat (150) tick();
      check("mid_rst_no_frames", n_frames, f0);

      // Push landing on the same edge as the final pop.
      f0 = n_frames;
      push_byte(8'($urandom_range(0, 255)));
      k = 0;
      while (!(nbits == 10 && ps2_clk_oe) && k < 300) begin tick(); k++; end
      check("reach_stop", (k < 300), 1);
      in_data = 8'($urandom_range(0, 255));
      repeat (3) tick();
      in_valid = 1'b1;
      tick();
      check("pop_push_count", fifo_count, 1);
      in_valid = 1'b0;
      k = 0;
      while (ps2_data_oe !== 1'b1 && k < 20) begin tick(); k++; end
      check("restart_gap", k, 1 + IDLE_CYC);
      wait_frames(f0 + 2, 300);

      // Random traffic with occasional host clock inhibit pulses.
      for (int i = 0; i < 20; i++) begin
         repeat ($urandom_range(0, 120)) tick();
         push_byte(8'($urandom_range(0, 255)));
         if ($urandom_range(0, 3) == 0) begin
            host_clk_low = 1'b1;
            repeat ($urandom_range(1, 6)) tick();
            host_clk_low = 1'b0;
         end
      end
      wait_idle(4000);
      repeat (5) tick();
      check("end_busy", busy, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
